instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_buf.sv | 33 +++
 rtl/instr_fetch.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared widths, state encoding and PC helper for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int WORD_W  = 16;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        HOLD
    } fetch_state_t;

    // Word-address arithmetic wraps at 2^16.
    function automatic logic [WORD_W-1:0] pc_add(input logic [WORD_W-1:0] base,
                                                 input logic [WORD_W-1:0] inc);
        return base + inc;
    endfunction

endpackage

// File: rtl/instr_fetch_buf.sv
// One-entry instruction+PC holding register; flush beats load, load beats unload.
module fetch_buf
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [WORD_W-1:0]  load_pc,
    output logic               buf_valid,
    output logic [INSTR_W-1:0] buf_instr,
    output logic [WORD_W-1:0]  buf_pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_instr <= load_instr;
            buf_pc    <= load_pc;
        end else if (unload) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads two 16-bit words per instruction and hands them to decode.
// Define INSTR_FETCH_PREFETCH_EN to decouple the output register and add a one-entry buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [WORD_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [WORD_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [WORD_W-1:0]  redirect_pc
);

    fetch_state_t       state;
    logic [WORD_W-1:0]  pc;
    logic [WORD_W-1:0]  hi_word;
    logic [INSTR_W-1:0] assembled;

    assign assembled = {hi_word, mem_rdata};
    assign mem_req   = (state == FETCH_HI) || (state == FETCH_LO);

    always_comb begin
        mem_addr = pc;
        if (state == FETCH_LO) begin
            mem_addr = pc_add(pc, 16'd1);
        end
    end

`ifdef INSTR_FETCH_PREFETCH_EN

    logic               out_free;
    logic               buf_load;
    logic               buf_unload;
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [WORD_W-1:0]  buf_pc;

    // The output can take a new instruction if it is empty or drained this cycle.
    assign out_free   = !instr_valid || instr_ready;
    assign buf_load   = (state == FETCH_LO) && mem_ack && !out_free;
    assign buf_unload = (state == HOLD) && buf_valid && instr_ready;

    fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .unload     (buf_unload),
        .flush      (redirect_valid),
        .load_instr (assembled),
        .load_pc    (pc),
        .buf_valid  (buf_valid),
        .buf_instr  (buf_instr),
        .buf_pc     (buf_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            hi_word     <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            state       <= FETCH_HI;
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state <= FETCH_HI;
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        hi_word <= mem_rdata;
                        state   <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        pc <= pc_add(pc, 16'd2);
                        if (out_free) begin
                            instr       <= assembled;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= FETCH_HI;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (buf_unload) begin
                        instr       <= buf_instr;
                        instr_pc    <= buf_pc;
                        instr_valid <= 1'b1;
                        state       <= FETCH_HI;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`else

    // Redirect discards any beat acked in the same cycle; a coincident handshake still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            hi_word     <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            state       <= FETCH_HI;
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH_HI;
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        hi_word <= mem_rdata;
                        state   <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        instr       <= assembled;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc_add(pc, 16'd2);
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH_HI;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: latency table, throughput, backpressure, redirect and wrap cases.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef INSTR_FETCH_PREFETCH_EN
    localparam int          EXP_INTERVAL = 2;
    localparam logic [15:0] EXP_RESUME   = 16'h0004;
`else
    localparam int          EXP_INTERVAL = 3;
    localparam logic [15:0] EXP_RESUME   = 16'h0002;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cycle_cnt  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
    } exp_t;

    typedef struct {
        int          wait_states;
        int          exp_latency;
        logic [15:0] exp_third_addr;
    } lat_vec_t;

    exp_t        exp_q[$];
    logic [15:0] beat_q[$];
    int          hs_q[$];

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        if (addr == 16'h0000) return 16'h1234;
        if (addr == 16'h0001) return 16'h5678;
        return {addr[7:0] ^ 8'hA5, addr[15:8] ^ 8'h3C};
    endfunction

    function automatic void pushExpected(input logic [15:0] pc);
        exp_t e;
        e.instr = {mem_word(pc), mem_word(pc + 16'd1)};
        e.pc    = pc;
        exp_q.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    // Memory model: acks after wait_states idle cycles of a steady request.
    int          wait_states = 0;
    int          wait_cnt    = 0;
    logic [15:0] last_addr   = '0;

    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (mem_addr != last_addr) wait_cnt = 0;
            last_addr = mem_addr;
            if (wait_cnt >= wait_states) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hDEAD;
                wait_cnt++;
            end
        end
    end

    // Monitor: scoreboard pops on handshake, logs acked beats, checks held request/output stability.
    logic        prev_req_wait = 1'b0;
    logic        prev_hold     = 1'b0;
    logic [15:0] prev_addr     = '0;
    logic [31:0] prev_instr    = '0;
    logic [15:0] prev_pc       = '0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (prev_req_wait) begin
            checkOutput("req_held", 32'(mem_req), 32'd1);
            checkOutput("addr_held", 32'(mem_addr), 32'(prev_addr));
        end
        if (prev_hold) begin
            checkOutput("hold_valid", 32'(instr_valid), 32'd1);
            checkOutput("hold_instr", instr, prev_instr);
            checkOutput("hold_pc", 32'(instr_pc), 32'(prev_pc));
        end
        if (!rst && instr_valid && instr_ready) begin
            hs_q.push_back(cycle_cnt);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_instr", instr, e.instr);
                checkOutput("sb_pc", 32'(instr_pc), 32'(e.pc));
            end
        end
        if (!rst && mem_req && mem_ack) beat_q.push_back(mem_addr);
        prev_req_wait = mem_req && !mem_ack && !rst && !redirect_valid;
        prev_hold     = instr_valid && !instr_ready && !rst && !redirect_valid;
        prev_addr     = mem_addr;
        prev_instr    = instr;
        prev_pc       = instr_pc;
    end

    // Holds reset for two cycles, checks reset values, then releases on a falling edge.
    task automatic applyStimulus(input int waits, input logic ready);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = ready;
        wait_states    = waits;
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'd0);
        rst = 1'b0;
    endtask

    task automatic waitDrained(input string name);
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(negedge clk);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        lat_vec_t lat_vecs[4];
        int       cycles;

        $display("[TB] Starting instr_fetch test");
        // Two beats per instruction, each stretched by the wait count.
        lat_vecs[0] = '{0, 3, 16'h0002};
        lat_vecs[1] = '{1, 5, 16'h0002};
        lat_vecs[2] = '{2, 7, 16'h0002};
        lat_vecs[3] = '{3, 9, 16'h0002};

        for (int v = 0; v < 4; v++) begin
            exp_q.delete();
            beat_q.delete();
            pushExpected(RESET_PC);
            applyStimulus(lat_vecs[v].wait_states, 1'b1);
            cycles = 0;
            while (cycles < 40 && !instr_valid) begin
                @(negedge clk);
                cycles++;
            end
            checkOutput("latency", 32'(cycles), 32'(lat_vecs[v].exp_latency));
            checkOutput("first_instr", instr, 32'h12345678);
            checkOutput("first_pc", 32'(instr_pc), 32'(RESET_PC));
            for (int i = 0; i < 60 && beat_q.size() < 3; i++) @(negedge clk);
            checkOutput("beat_count", 32'(beat_q.size() >= 3), 32'd1);
            if (beat_q.size() >= 3) checkOutput("third_req", 32'(beat_q[2]), 32'(lat_vecs[v].exp_third_addr));
            waitDrained("lat_drained");
        end

        $display("[TB] Throughput");
        exp_q.delete();
        hs_q.delete();
        for (int k = 0; k < 4; k++) pushExpected(RESET_PC + 16'(2 * k));
        applyStimulus(0, 1'b1);
        for (int i = 0; i < 60 && hs_q.size() < 4; i++) @(negedge clk);
        checkOutput("tp_count", 32'(hs_q.size() >= 4), 32'd1);
        if (hs_q.size() >= 4) begin
            checkOutput("tp_interval_a", 32'(hs_q[2] - hs_q[1]), 32'(EXP_INTERVAL));
            checkOutput("tp_interval_b", 32'(hs_q[3] - hs_q[2]), 32'(EXP_INTERVAL));
        end
        waitDrained("tp_drained");

        $display("[TB] Decode backpressure");
        exp_q.delete();
        pushExpected(RESET_PC);
`ifdef INSTR_FETCH_PREFETCH_EN
        pushExpected(RESET_PC + 16'd2);
`endif
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 40 && !instr_valid; i++) @(negedge clk);
        checkOutput("bp_valid", 32'(instr_valid), 32'd1);
`ifdef INSTR_FETCH_PREFETCH_EN
        repeat (3) @(negedge clk);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_no_req", 32'(mem_req), 32'd0);
            checkOutput("bp_pc", 32'(instr_pc), 32'(RESET_PC));
        end
        beat_q.delete();
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && beat_q.size() < 1; i++) @(negedge clk);
        checkOutput("bp_beats", 32'(beat_q.size() >= 1), 32'd1);
        if (beat_q.size() >= 1) checkOutput("bp_resume_addr", 32'(beat_q[0]), 32'(EXP_RESUME));
        waitDrained("bp_drained");

        $display("[TB] Redirect in FETCH_LO");
        exp_q.delete();
        applyStimulus(0, 1'b1);
        for (int i = 0; i < 30 && !(mem_req && mem_addr == 16'h0005); i++) @(negedge clk);
        checkOutput("redir_reach", 32'(mem_req && mem_addr == 16'h0005), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        beat_q.delete();
        pushExpected(16'h0100);
        checkOutput("redir_req", 32'(mem_req), 32'd1);
        checkOutput("redir_addr", 32'(mem_addr), 32'h0100);
        waitDrained("redir_drained");

        $display("[TB] Wrap-around");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        beat_q.delete();
        pushExpected(16'hFFFF);
        for (int i = 0; i < 40 && beat_q.size() < 3; i++) @(negedge clk);
        checkOutput("wrap_beats", 32'(beat_q.size() >= 3), 32'd1);
        if (beat_q.size() >= 3) begin
            checkOutput("wrap_hi", 32'(beat_q[0]), 32'hFFFF);
            checkOutput("wrap_lo", 32'(beat_q[1]), 32'h0000);
            checkOutput("wrap_next", 32'(beat_q[2]), 32'h0001);
        end
        waitDrained("wrap_drained");

        $display("[TB] Redirect while decode stalls");
        exp_q.delete();
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 40 && !instr_valid; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checkOutput("flush_valid", 32'(instr_valid), 32'd0);
        pushExpected(16'h0200);
        pushExpected(16'h0202);
        instr_ready = 1'b1;
        waitDrained("flush_drained");

        $display("[TB] Reset mid-fetch");
        applyStimulus(3, 1'b1);
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
